// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller: one-hot registered grant, one-cycle GAP between owners.
// Define ARB_TIMEOUT_EN to build the MAX_HOLD forced-release limit and the tout pulse.
module rr_grant_ctrl #(
  parameter int unsigned N        = 4,
  parameter int unsigned IW       = 2,
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CW       = 4
) (
  input  logic          C,
  input  logic          R,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gidx,
  output logic          busy,
  output logic          tout
);

  localparam int unsigned SW = IW + 1;

  if (N < 2 || N > 8 || (2 ** IW) < N || MAX_HOLD < 1 || (2 ** CW) <= MAX_HOLD) begin : g_param_check
    $error("rr_grant_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        r_state, w_nxt_state;
  logic [N-1:0]  r_gnt, w_nxt_gnt;
  logic [IW-1:0] r_gidx, w_nxt_gidx;
  logic          r_busy, w_nxt_busy;
  logic [IW-1:0] r_ptr, w_nxt_ptr;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic [SW-1:0] w_sum;
  logic [N-1:0]  w_pick_oh;
  logic          w_owner_req;
  logic [IW-1:0] w_ptr_after_owner;

`ifdef ARB_TIMEOUT_EN
  logic [CW-1:0] r_cnt, w_nxt_cnt;
  logic          r_tout, w_nxt_tout;
`endif

  // Scan ptr, ptr+1, ... (mod N) for the first active request.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_sum = {1'b0, r_ptr} + SW'(k);
      if (w_sum >= SW'(N)) w_sum = w_sum - SW'(N);
      if (!w_found && req[w_sum[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[IW-1:0];
      end
    end
  end

  assign w_pick_oh         = {{(N-1){1'b0}}, 1'b1} << w_pick;
  assign w_owner_req       = |(req & r_gnt);
  assign w_ptr_after_owner = (r_gidx == IW'(N - 1)) ? '0 : r_gidx + IW'(1);

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_gidx  <= '0;
      r_busy  <= 1'b0;
      r_ptr   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tout  <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_gidx  <= w_nxt_gidx;
      r_busy  <= w_nxt_busy;
      r_ptr   <= w_nxt_ptr;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= w_nxt_cnt;
      r_tout  <= w_nxt_tout;
`endif
    end
  end

  // Arbitrate only in IDLE; the owner keeps the grant until it drops req (or times out).
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_gidx  = r_gidx;
    w_nxt_busy  = r_busy;
    w_nxt_ptr   = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_nxt_cnt   = r_cnt;
    w_nxt_tout  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_state = S_GRANT;
          w_nxt_gnt   = w_pick_oh;
          w_nxt_gidx  = w_pick;
          w_nxt_busy  = 1'b1;
`ifdef ARB_TIMEOUT_EN
          w_nxt_cnt   = CW'(1);
`endif
        end
      end
      S_GRANT: begin
        if (!w_owner_req) begin
          w_nxt_state = S_GAP;
          w_nxt_gnt   = '0;
          w_nxt_busy  = 1'b0;
          w_nxt_ptr   = w_ptr_after_owner;
`ifdef ARB_TIMEOUT_EN
        end else if (r_cnt == CW'(MAX_HOLD)) begin
          w_nxt_state = S_GAP;
          w_nxt_gnt   = '0;
          w_nxt_busy  = 1'b0;
          w_nxt_ptr   = w_ptr_after_owner;
          w_nxt_tout  = 1'b1;
        end else begin
          w_nxt_cnt   = r_cnt + CW'(1);
`endif
        end
      end
      S_GAP: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_gnt   = '0;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  assign gnt  = r_gnt;
  assign gidx = r_gidx;
  assign busy = r_busy;
`ifdef ARB_TIMEOUT_EN
  assign tout = r_tout;
`else
  assign tout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Self-checking bench for rr_grant_ctrl: directed table, multi-cycle sequences and
// random stimulus compared against a behavioural owner/pointer model.
module tb_rr_grant_ctrl;

  localparam int N        = 4;
  localparam int MAX_HOLD = 15;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       C = 1'b0;
  logic       R = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gidx;
  logic       busy;
  logic       tout;

  int vectors     = 0;
  int miscompares = 0;

  rr_grant_ctrl #(.N(4), .IW(2), .MAX_HOLD(15), .CW(4)) dut (
    .C(C), .R(R), .req(req), .gnt(gnt), .gidx(gidx), .busy(busy), .tout(tout)
  );

  always #5 C = ~C;

  // Behavioural model: owner (-1 = none), one-cycle gap flag, rotating pointer, hold count.
  int m_owner, m_ptr, m_hold, m_last;
  bit m_gap, m_tout;

  function automatic void model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_last = 0; m_gap = 1'b0; m_tout = 1'b0;
  endfunction

  function automatic void model_release();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_gap   = 1'b1;
  endfunction

  function automatic void model_edge(input logic [3:0] r);
    m_tout = 1'b0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) model_release();
      else if (TO_EN && m_hold == MAX_HOLD) begin
        model_release();
        m_tout = 1'b1;
      end else if (m_hold < MAX_HOLD) m_hold++;
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && r[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_last  = m_owner;
          m_hold  = 1;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge C);
    if (R) model_reset();
    else model_edge(req);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] eg, input logic [1:0] ei,
                       input logic eb, input logic et);
    vectors++;
    if (gnt !== eg || gidx !== ei || busy !== eb || tout !== et || !$onehot0(gnt) || busy !== |gnt) begin
      miscompares++;
      $display("FAIL %s @%0t: got gnt=%b gidx=%0d busy=%b tout=%b, want gnt=%b gidx=%0d busy=%b tout=%b",
               nm, $time, gnt, gidx, busy, tout, eg, ei, eb, et);
    end
  endtask

  task automatic check_model(input string nm);
    logic [3:0] eg;
    eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    check(nm, eg, 2'(m_last), m_owner >= 0, m_tout);
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", nm, got, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gidx;
    logic       busy;
    logic       tout;
  } vec_t;

  vec_t tbl[18];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int   order[$];
    int   held[4];
    int   off[4];
    int   exp_order[6];
    logic [3:0] prev_gnt;
    model_reset();

    // Reset hold, single grant, GAP, pointer wrap and skip.
    tbl[0]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'b1001, 4'b0000, 2'd2, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 4'b0001, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'b1001, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 1'b0};

    #1;
    check("reset_level", 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      R   = tbl[i].rst;
      req = tbl[i].req;
      tick();
      check($sformatf("table[%0d]", i), tbl[i].gnt, tbl[i].gidx, tbl[i].busy, tbl[i].tout);
    end

    // Asynchronous reset between edges while owner 1 holds the grant.
    req = 4'b0010;
    tick();
    check("arst_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
    #2;
    R = 1'b1;
    model_reset();
    #1;
    check("arst_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    R = 1'b0;
    req = 4'b0000;
    tick();
    check("arst_release", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Round robin: each requester drops 3 cycles after its grant, re-raises 2 later.
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin held[i] = 0; off[i] = 0; end
    prev_gnt = 4'b0000;
    req = 4'b1111;
    for (int cyc = 0; cyc < 80 && order.size() < 6; cyc++) begin
      tick();
      check_model("rr_cycle");
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) order.push_back(int'(gidx));
      prev_gnt = gnt;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          held[i]++;
          if (held[i] == 3) begin req[i] = 1'b0; held[i] = 0; off[i] = 2; end
        end else if (!req[i]) begin
          if (off[i] > 0) off[i]--;
          if (off[i] == 0) req[i] = 1'b1;
        end
      end
    end
    for (int j = 0; j < 6; j++)
      check_int($sformatf("rr_order[%0d]", j), (j < order.size()) ? order[j] : -1, exp_order[j]);

    // Constant req=0011: forced rotation with the limit built, permanent owner 0 without.
    R = 1'b1;
    tick();
    R = 1'b0;
    req = 4'b0011;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (TO_EN) begin
        int pos;
        int own;
        pos = (c - 1) % 17;
        own = ((c - 1) / 17) % 2;
        if (pos < 15) check("hold_owner", 4'(1 << own), 2'(own), 1'b1, 1'b0);
        else if (pos == 15) check("hold_tout", 4'b0000, 2'(own), 1'b0, 1'b1);
        else check("hold_gap", 4'b0000, 2'(own), 1'b0, 1'b0);
      end else begin
        check("hold_forever", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
    end

    // Random requests with a sticky owner and occasional asynchronous resets.
    req = 4'b0000;
    R = 1'b1;
    tick();
    R = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req = 4'($urandom);
      if (m_owner >= 0 && $urandom_range(0, 7) != 0) req[m_owner] = 1'b1;
      tick();
      check_model("random");
      if ($urandom_range(0, 63) == 0) begin
        #2;
        R = 1'b1;
        model_reset();
        #1;
        check_model("random_arst");
        tick();
        R = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_grant_ctrl.md
Name: rr_grant_ctrl

Overview:
- Round-robin arbiter/sequencer that shares one datapath resource between N requesters.
- One-hot registered grant, with a one-cycle turnaround gap between owners.
- Optional hold-time limit so a requester cannot monopolise the resource.
- Sits between requesting blocks and the shared resource; gnt drives resource enables/muxes.

Parameters:
N, 4, number of requesters (2..8)
IW, 2, width of grant index; must satisfy 2**IW >= N
MAX_HOLD, 15, max consecutive grant cycles per ownership (>=1); used only with ARB_TIMEOUT_EN
CW, 4, hold counter width; must satisfy 2**CW > MAX_HOLD

Ports:
C  input  1  clock, rising edge
R  input  1  reset, asynchronous, active-high
req  input  N  request per requester, level, held while resource wanted
gnt  output  N  registered one-hot grant; all-zero when no owner
gidx  output  IW  index of current owner; holds last owner when gnt=0
busy  output  1  high while any gnt bit high
tout  output  1  one-cycle pulse when a grant is force-released

Behaviour:
- Clock C; reset R asynchronous, active-high.
- While R=1: state=IDLE, gnt=0, gidx=0, busy=0, tout=0, ptr=0, cnt=0; applied immediately, no clock edge needed.
- All outputs registered on rising C; no combinational path from req to outputs.
- States: IDLE, GRANT, GAP.
- IDLE:
  - Arbitration only occurs here.
  - If req!=0 at an edge: owner = first set bit scanning ptr, ptr+1, ... mod N.
  - That edge sets gnt=onehot(owner), gidx=owner, busy=1, cnt=1, state=GRANT (latency 1 cycle).
  - If req=0: stay IDLE.
- GRANT:
  - Release if req[owner]=0 at an edge: gnt=0, busy=0, state=GAP, ptr=(owner+1) mod N.
  - Else cnt increments (saturating at MAX_HOLD) and the grant holds.
  - Non-owner req bits are ignored in GRANT.
- GAP:
  - Exactly one cycle, gnt=0, no arbitration; next edge -> IDLE.
  - Requests pending in GAP are granted from IDLE. Minimum owner-to-owner gap is 2 cycles of gnt=0 (GAP + IDLE arbitration edge).
- Pointer:
  - Wraps N-1 -> 0.
  - Only updated on release, never on request arrival.
  - Reset mid-operation returns ptr to 0.
- gidx: retains last owner after release; resets to 0.
- Simultaneous events:
  - Owner dropping req on the same edge the hold limit hits counts as a normal release, tout=0.
  - Reset always wins over any edge.
- Invariants:
  - $onehot0(gnt) at all times.
  - busy == |gnt.
  - tout never high while gnt!=0 after the edge it pulses.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if cnt==MAX_HOLD and req[owner] still 1 at an edge: forced release. gnt=0, busy=0, state=GAP, ptr=(owner+1) mod N, tout=1 for exactly that cycle.
  - Owner keeping req high rejoins arbitration at lowest priority.
- Undefined:
  - cnt and the timeout compare are not built.
  - tout tied to 0.
  - Grant held until the owner drops req, indefinitely.

Test Plan:
- Reset: R=1 with req=4'b1111 for 3 edges -> gnt=0, gidx=0, busy=0, tout=0. Assert R mid-GRANT (gnt=4'b0010) between edges -> gnt=0 before next edge.
- Single grant: after reset, req=4'b0100 at edge k -> gnt=4'b0100, gidx=2, busy=1 after edge k. Drop req at edge k+5 -> gnt=0 after k+5, GAP at k+6, IDLE after k+6.
- Round robin: each requester drops req 3 cycles after its grant and re-raises 2 cycles later, with all four active -> grant order 0,1,2,3,0,1. Never two gnt bits set.
- Pointer wrap and skip: after owner 3 releases, req=4'b1001 -> next grant 0. After owner 0 releases, req=4'b1001 -> grant 3 (skips 1, 2).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=15): req=4'b0011 held constantly -> owner 0 for 15 cycles, tout pulse 1 cycle at release, then owner 1 for 15 cycles, tout again, then owner 0.
- No timeout (macro undefined): req=4'b0011 held constantly for 100 cycles -> gnt=4'b0001 throughout, tout=0.
